// File: rtl/s2p_in.sv
// s2p_in: drives an external parallel-in/serial-out shift-register chain.
// The chain is loaded and then clocked out one bit at a time. The bits are
// gathered into an internal register, and the finished word is published on
// P_Data together with a one-cycle Valid pulse.
//
// Start and Auto pass through one input register before the FSM looks at
// them. Start is therefore "sampled" on the edge that captures it, and the
// FSM leaves IDLE on the following edge.
//
// s_clk, s_load_n, Valid and Busy are registered. Each is decoded from the
// next state, so it always matches the state the FSM is currently in and
// cannot glitch.

module s2p_in #(
    parameter int DATA_BITS       = 64,
    parameter int DATA_COUNT_BITS = 6,
    parameter int DIR             = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Start,
    input  logic                 Auto,
    input  logic                 sin,
    output logic                 s_clk,
    output logic                 s_load_n,
    output logic [DATA_BITS-1:0] P_Data,
    output logic                 Valid,
    output logic                 Busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } state_t;

    localparam logic [DATA_COUNT_BITS-1:0] LAST_BIT = DATA_COUNT_BITS'(DATA_BITS - 1);

    state_t                     state_q,    state_d;
    logic [DATA_COUNT_BITS-1:0] cnt_q,      cnt_d;
    logic [DATA_BITS-1:0]       shreg_q,    shreg_d;
    logic [DATA_BITS-1:0]       p_data_q,   p_data_d;
    logic                       s_clk_q,    s_clk_d;
    logic                       s_load_n_q, s_load_n_d;
    logic                       valid_q,    valid_d;
    logic                       busy_q,     busy_d;
    logic                       start_q,    start_d;
    logic                       auto_q,     auto_d;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        p_data_d = p_data_q;
        start_d  = Start;
        auto_d   = Auto;

        case (state_q)
            IDLE: begin
                if (start_q || auto_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = SHIFT_LO;
            end
            SHIFT_LO: begin
                // The chain's current output bit is taken on the edge that raises s_clk.
                if (DIR != 0) begin
                    shreg_d = {shreg_q[DATA_BITS-2:0], sin};
                end else begin
                    shreg_d = {sin, shreg_q[DATA_BITS-1:1]};
                end
                state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (cnt_q == LAST_BIT) begin
                    // Only a complete word is ever copied to P_Data.
                    p_data_d = shreg_q;
                    state_d  = DONE;
                end else begin
                    cnt_d   = cnt_q + DATA_COUNT_BITS'(1);
                    state_d = SHIFT_LO;
                end
            end
            DONE: begin
                state_d = auto_q ? LOAD : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        s_clk_d    = (state_d == SHIFT_HI);
        s_load_n_d = (state_d != LOAD);
        valid_d    = (state_d == DONE);
        busy_d     = (state_d != IDLE);
    end

    // State, datapath and output registers; reset aborts any capture in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            p_data_q   <= '0;
            s_clk_q    <= 1'b0;
            s_load_n_q <= 1'b1;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            auto_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register updates from pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            p_data_q   <= p_data_d;
            s_clk_q    <= s_clk_d;
            s_load_n_q <= s_load_n_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            start_q    <= start_d;
            auto_q     <= auto_d;
        end
    end

    assign s_clk    = s_clk_q;
    assign s_load_n = s_load_n_q;
    assign P_Data   = p_data_q;
    assign Valid    = valid_q;
    assign Busy     = busy_q;

endmodule

// File: tb/tb_s2p_in.sv
// Directed bench for s2p_in. It runs one DIR=1 instance and one DIR=0 instance.
// Each instance is paired with a model of an external PISO chain. The chain
// loads its preset word when s_load_n falls and presents the MSB first; each
// rising edge of s_clk moves it to the next bit.

module tb_s2p_in;

    localparam int DB  = 8;
    localparam int DCB = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start1, auto1, sin1, sclk1, sld1, valid1, busy1;
    logic [DB-1:0] pdata1;
    logic          start0, auto0, sin0, sclk0, sld0, valid0, busy0;
    logic [DB-1:0] pdata0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    s2p_in #(.DATA_BITS(DB), .DATA_COUNT_BITS(DCB), .DIR(1)) u_dut1 (
        .clk(clk), .rst(rst), .Start(start1), .Auto(auto1), .sin(sin1),
        .s_clk(sclk1), .s_load_n(sld1), .P_Data(pdata1), .Valid(valid1), .Busy(busy1)
    );

    s2p_in #(.DATA_BITS(DB), .DATA_COUNT_BITS(DCB), .DIR(0)) u_dut0 (
        .clk(clk), .rst(rst), .Start(start0), .Auto(auto0), .sin(sin0),
        .s_clk(sclk0), .s_load_n(sld0), .P_Data(pdata0), .Valid(valid0), .Busy(busy0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // External chain models.
    logic [DB-1:0] pre1 = '0, ch1 = '0, pre0 = '0, ch0 = '0;
    int            k1 = 0, k0 = 0;

    always @(negedge sld1) ch1 = pre1;
    always @(negedge sld0) ch0 = pre0;
    always @(posedge sclk1 or negedge sld1) k1 = sld1 ? k1 + 1 : 0;
    always @(posedge sclk0 or negedge sld0) k0 = sld0 ? k0 + 1 : 0;
    assign sin1 = (k1 < DB) ? ch1[DB-1-k1] : 1'b0;
    assign sin0 = (k0 < DB) ? ch0[DB-1-k0] : 1'b0;

    // Event counters and always-on protocol checks.
    int   cyc = 0, sclk_edges1 = 0, valid_cnt1 = 0, load_cyc1 = 0, idle_cyc1 = 0;
    logic valid1_prev = 1'b0, valid0_prev = 1'b0;

    always @(posedge clk) cyc++;
    always @(posedge sclk1) sclk_edges1++;

    always @(negedge clk) begin
        if (valid1) valid_cnt1++;
        if (!sld1)  load_cyc1++;
        if (!busy1) idle_cyc1++;
        check("load_vs_sclk_dir1", 64'(!sld1 && sclk1), 64'd0);
        check("load_vs_sclk_dir0", 64'(!sld0 && sclk0), 64'd0);
        check("valid_width_dir1", 64'(valid1 && valid1_prev), 64'd0);
        check("valid_width_dir0", 64'(valid0 && valid0_prev), 64'd0);
        valid1_prev = valid1;
        valid0_prev = valid0;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for the next Valid on the DIR=1 instance; returns its cycle.
    task automatic wait_valid1(output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (valid1) begin
                at_cyc = cyc;
                return;
            end
        end
        check("valid1_timeout", 64'd1, 64'd0);
    endtask

    task automatic pulse_start1();
        start1 = 1'b1;
        tick(1);
        start1 = 1'b0;
    endtask

    int s0, v0, l0, b0, c1, c2, lat;

    initial begin
        rst = 1'b1; start1 = 1'b0; auto1 = 1'b0; start0 = 1'b0; auto0 = 1'b0;
        tick(2);
        check("rst_pdata", 64'(pdata1), 64'd0);
        check("rst_sclk", 64'(sclk1), 64'd0);
        check("rst_sload_n", 64'(sld1), 64'd1);
        check("rst_valid", 64'(valid1), 64'd0);
        check("rst_busy", 64'(busy1), 64'd0);
        rst = 1'b0;
        tick(3);
        check("idle_busy", 64'(busy1), 64'd0);

        // DIR=1, chain 8'hA5, single Start pulse, cycle-exact timeline.
        pre1 = 8'hA5;
        s0 = sclk_edges1; v0 = valid_cnt1; l0 = load_cyc1;
        pulse_start1();                      // now just after E0
        check("e0_still_idle", 64'(busy1), 64'd0);
        tick(1);                             // LOAD
        check("load_sload_n", 64'(sld1), 64'd0);
        check("load_sclk", 64'(sclk1), 64'd0);
        check("load_busy", 64'(busy1), 64'd1);
        tick(1);                             // SHIFT_LO
        check("slo_sclk", 64'(sclk1), 64'd0);
        check("slo_sload_n", 64'(sld1), 64'd1);
        tick(1);                             // SHIFT_HI
        check("shi_sclk", 64'(sclk1), 64'd1);
        tick(14);                            // E0+17
        check("valid_not_early", 64'(valid1), 64'd0);
        tick(1);                             // E0+18
        check("a5_valid", 64'(valid1), 64'd1);
        check("a5_pdata", 64'(pdata1), 64'hA5);
        check("done_busy", 64'(busy1), 64'd1);
        tick(1);
        check("after_done_valid", 64'(valid1), 64'd0);
        check("after_done_busy", 64'(busy1), 64'd0);
        check("a5_sclk_edges", 64'(sclk_edges1 - s0), 64'd8);
        check("a5_load_cycles", 64'(load_cyc1 - l0), 64'd1);
        check("a5_valid_count", 64'(valid_cnt1 - v0), 64'd1);
        tick(5);
        check("pdata_holds", 64'(pdata1), 64'hA5);

        // DIR=0, chain 8'h01 read MSB first: the final 1 lands in bit 7.
        pre0 = 8'h01;
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (valid0) begin
                lat = i;
                break;
            end
        end
        check("dir0_latency", 64'(lat), 64'd18);
        check("dir0_pdata", 64'(pdata0), 64'h80);
        tick(2);

        // Start held high without Auto: one IDLE cycle between captures.
        pre1 = 8'h96;
        start1 = 1'b1;
        wait_valid1(c1);
        check("held_first_pdata", 64'(pdata1), 64'h96);
        pre1 = 8'h69;
        wait_valid1(c2);
        start1 = 1'b0;
        check("held_spacing", 64'(c2 - c1), 64'd19);
        check("held_second_pdata", 64'(pdata1), 64'h69);
        tick(25);
        check("held_back_idle", 64'(busy1), 64'd0);

        // Auto: back-to-back captures with no IDLE cycle in between.
        pre1 = 8'h3C;
        auto1 = 1'b1;
        wait_valid1(c1);
        check("auto_first_pdata", 64'(pdata1), 64'h3C);
        pre1 = 8'hC3;
        auto1 = 1'b0;
        b0 = idle_cyc1;
        wait_valid1(c2);
        check("auto_spacing", 64'(c2 - c1), 64'd18);
        check("auto_second_pdata", 64'(pdata1), 64'hC3);
        check("auto_no_idle", 64'(idle_cyc1 - b0), 64'd0);
        tick(1);
        check("auto_stops", 64'(busy1), 64'd0);

        // Reset at the 4th SHIFT_HI after a capture of 8'hFF.
        pre1 = 8'hFF;
        pulse_start1();
        wait_valid1(c1);
        check("ff_pdata", 64'(pdata1), 64'hFF);
        tick(1);
        pre1 = 8'h5A;
        pulse_start1();                      // just after E0
        tick(9);                             // 4th SHIFT_HI
        check("mid_shift_hi", 64'(sclk1), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("abort_pdata", 64'(pdata1), 64'd0);
        check("abort_sclk", 64'(sclk1), 64'd0);
        check("abort_sload_n", 64'(sld1), 64'd1);
        check("abort_busy", 64'(busy1), 64'd0);
        tick(1);
        rst = 1'b0;
        v0 = valid_cnt1;
        tick(30);
        check("abort_no_valid", 64'(valid_cnt1 - v0), 64'd0);
        check("abort_waits_idle", 64'(busy1), 64'd0);
        pulse_start1();
        wait_valid1(c1);
        check("after_abort_pdata", 64'(pdata1), 64'h5A);
        tick(2);

        // Start re-pulsed mid-capture must not restart or extend it.
        pre1 = 8'hE7;
        s0 = sclk_edges1; v0 = valid_cnt1;
        pulse_start1();
        tick(5);
        start1 = 1'b1;
        tick(2);
        start1 = 1'b0;
        wait_valid1(c1);
        check("repulse_pdata", 64'(pdata1), 64'hE7);
        tick(20);
        check("repulse_sclk_edges", 64'(sclk_edges1 - s0), 64'd8);
        check("repulse_valid_count", 64'(valid_cnt1 - v0), 64'd1);
        check("repulse_idle", 64'(busy1), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/s2p_in.md
S2P_IN -- requirements
Module: s2p_in

Interface
REQ-001 Parameter DATA_BITS, default 64, width of the parallel word captured from the external shift-register chain.
REQ-002 Parameter DATA_COUNT_BITS, default 6, width of the bit counter; the counter SHALL be wide enough to hold DATA_BITS-1.
REQ-003 Parameter DIR, default 1: 1 = first received bit lands in P_Data[DATA_BITS-1]; 0 = first received bit lands in P_Data[0].
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 Start  input  1  level-sampled request to capture one word.
REQ-007 Auto  input  1  when 1, a new capture SHALL begin immediately after each completed one.
REQ-008 sin  input  1  serial data from the last stage of the external chain.
REQ-009 s_clk  output  1  shift clock to the external chain; external stages shift on its rising edge.
REQ-010 s_load_n  output  1  active-low parallel-load strobe to the external chain.
REQ-011 P_Data  output  DATA_BITS  last completed captured word.
REQ-012 Valid  output  1  one-cycle pulse marking a new P_Data.
REQ-013 Busy  output  1  high while a capture is in progress.

Function
REQ-014 The block SHALL be a state machine with states IDLE, LOAD, SHIFT_LO, SHIFT_HI and DONE.
REQ-015 IDLE: s_clk=0, s_load_n=1, Busy=0; go to LOAD when Start=1 or Auto=1 is sampled.
REQ-016 LOAD: lasts exactly one cycle with s_load_n=0, s_clk=0, Busy=1; clear the counter to 0; go to SHIFT_LO.
REQ-017 SHIFT_LO: s_clk=0, s_load_n=1, Busy=1; sample sin into the internal shift register at the closing edge; go to SHIFT_HI.
REQ-018 SHIFT_HI: s_clk=1, Busy=1; if counter==DATA_BITS-1, go to DONE; otherwise increment the counter and go to SHIFT_LO.
REQ-019 With DIR=1, SHIFT_LO SHALL shift the internal register left and insert sin at bit 0; with DIR=0 it SHALL shift right and insert sin at bit DATA_BITS-1.
REQ-020 On the edge entering DONE, P_Data SHALL load the internal register; during DONE, Valid=1 and Busy=1.
REQ-021 DONE SHALL last one cycle, then go to LOAD if Auto=1 and to IDLE otherwise.
REQ-022 Latency: with Start sampled at edge E0, P_Data updates and Valid rises at edge E0+2*DATA_BITS+2; Valid falls one edge later.
REQ-023 s_clk, s_load_n, Valid and Busy SHALL be registered outputs, free of glitches.
REQ-024 Exactly DATA_BITS rising edges of s_clk SHALL occur per capture; s_load_n=0 and s_clk=1 SHALL never coincide.
REQ-025 Start or Auto changes during LOAD, SHIFT_LO or SHIFT_HI SHALL be ignored; the capture in progress is never restarted or extended.
REQ-026 Start held high continuously without Auto SHALL produce back-to-back captures, each separated by one IDLE cycle.
REQ-027 P_Data SHALL hold its value between captures; a partial capture SHALL never reach P_Data.

Reset
REQ-028 While rst=1, independent of clk: state=IDLE, counter=0, internal register=0, P_Data=0, s_clk=0, s_load_n=1, Valid=0, Busy=0.
REQ-029 Reset asserted mid-capture SHALL abort the capture; after release the block SHALL wait in IDLE for Start or Auto.

Verification (bench DATA_BITS=8, DATA_COUNT_BITS=3)
REQ-030 DIR=1, chain model preloaded 8'hA5, one-cycle Start pulse -> one s_load_n low cycle, 8 s_clk pulses, P_Data=8'hA5 and a one-cycle Valid at E0+18, then IDLE.
REQ-031 DIR=0, same 8'hA5 chain -> P_Data=8'hA5 bit-reversed, i.e. 8'hA5 read LSB-first = 8'hA5 reversed = 8'hA5? No: use 8'h01 instead -> P_Data=8'h80.
REQ-032 Auto=1, chain reloads 8'h3C then 8'hC3 -> Valid pulses exactly 18 cycles apart, with P_Data=8'h3C then 8'hC3 and no IDLE cycle between captures.
REQ-033 rst pulsed at the 4th SHIFT_HI, after a prior capture of 8'hFF -> immediate P_Data=0, s_clk=0, s_load_n=1; no Valid until a new Start; the next capture is correct.
REQ-034 Start re-pulsed while Busy=1 -> no restart; exactly 8 s_clk edges and one Valid per capture.
REQ-035 Throughout every test, assert that s_load_n=0 and s_clk=1 never coincide and that Valid never lasts longer than one cycle.
